// File: rtl/mmio_fabric_pkg.sv
// Shared types and constants for the MMIO fabric.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fab_state_t;

  localparam int FAULT_CNT_W = 16;

  // Timeout counter width: enough to hold TIMEOUT, never narrower than 1 bit.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 0) ? 1 : (($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1));
  endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Priority address decoder: base/mask windows, lowest matching slot wins.
// Latency: combinational.
// Backpressure: none; pure function of the address.
module mmio_addr_decoder #(
  parameter int NUM_SLAVES = 8,
  parameter int SEL_W      = 3
) (
  input  logic [31:0]              addr,
  input  logic [NUM_SLAVES*32-1:0] base,
  input  logic [NUM_SLAVES*32-1:0] mask,
  output logic                     hit,
  output logic [SEL_W-1:0]         sel_idx
);

  // Walk from the highest slot down so the lowest matching slot is written last.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask[32*i +: 32]) == base[32*i +: 32]) begin
        hit     = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// MMIO fabric: CPU data port to N peripheral slaves, with timeout and unmapped-fault reporting.
// Latency: m_ready 3 cycles after m_valid for a zero-wait slave, +1 per slave wait; 2 for unmapped.
// Backpressure: master holds m_valid until the one-cycle m_ready pulse; slaves stall via s_ready.
module mmio_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int                     NUM_SLAVES        = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE      = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK      = '0,
  parameter int                     TIMEOUT           = 255,
  parameter bit                     FAULT_ON_UNMAPPED = 1'b1,
  parameter logic [31:0]            FAULT_RDATA       = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic                     m_fault,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     busy,
  output logic [FAULT_CNT_W-1:0]   fault_cnt
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  fab_state_t             state_q, state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [31:0]            rdata_q;
  logic                   fault_q;
  logic                   dec_hit;
  logic [SEL_W-1:0]       dec_sel;
  logic [NUM_SLAVES-1:0]  dec_onehot;
  logic                   sel_ready;
  logic                   tmo;

  mmio_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .addr    (m_addr),
    .base    (SLAVE_BASE),
    .mask    (SLAVE_MASK),
    .hit     (dec_hit),
    .sel_idx (dec_sel)
  );

  // Selected-slave ready, timeout expiry and the one-hot form of the decoded slot.
  always_comb begin
    sel_ready = s_ready[sel_q];
    tmo       = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (dec_sel == SEL_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and master-side outputs; the response is driven only in RESP.
  always_comb begin
    state_d = state_q;
    m_ready = 1'b0;
    m_rdata = '0;
    m_fault = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: if (m_valid) state_d = dec_hit ? REQ : RESP;
      REQ:  if (sel_ready || tmo) state_d = RESP;
      RESP: begin
        m_ready = 1'b1;
        m_rdata = rdata_q;
        m_fault = fault_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, slave strobe, timeout counter, response capture and fault counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      fault_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_valid) begin
            if (dec_hit) begin
              s_addr  <= m_addr;
              s_wdata <= m_wdata;
              s_wstrb <= m_wstrb;
              sel_q   <= dec_sel;
              s_valid <= dec_onehot;
              cnt_q   <= '0;
            end else begin
              rdata_q <= FAULT_RDATA;
              fault_q <= FAULT_ON_UNMAPPED;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Ready takes priority over a timeout landing in the same cycle.
          if (sel_ready) begin
            rdata_q <= s_rdata[32*sel_q +: 32];
            fault_q <= 1'b0;
            s_valid <= '0;
          end else if (tmo) begin
            rdata_q <= FAULT_RDATA;
            fault_q <= 1'b1;
            s_valid <= '0;
          end
        end
        RESP: begin
          if (fault_q && (fault_cnt != {FAULT_CNT_W{1'b1}})) begin
            fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fabric.sv
// Self-checking bench for mmio_fabric: schedule-based reference model plus directed literals.
// Latency: n/a.
// Backpressure: slave readiness is scripted per transaction from a chosen wait count.
module tb_mmio_fabric;

  localparam int          N   = 4;
  localparam int          TMO = 8;
  localparam logic [31:0] FRD = 32'hDEAD_BEEF;

  // Slot windows: slot1 and slot3 overlap on 0x4000_00xx.
  localparam logic [N*32-1:0] P_BASE = {32'h4000_0000, 32'h1000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] P_MASK = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_F000};
  localparam logic [31:0] BASES [N] = '{32'h0000_0000, 32'h4000_0000, 32'h1000_0000, 32'h4000_0000};
  localparam logic [31:0] MASKS [N] = '{32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_0000};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_valid = 1'b0;
  logic [31:0]     m_addr = '0;
  logic [31:0]     m_wdata = '0;
  logic [3:0]      m_wstrb = '0;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic            m_fault;
  logic [N-1:0]    s_valid;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic [N-1:0]    s_ready = '0;
  logic [N*32-1:0] s_rdata = '0;
  logic            busy;
  logic [15:0]     fault_cnt;

  mmio_fabric #(
    .NUM_SLAVES        (N),
    .SLAVE_BASE        (P_BASE),
    .SLAVE_MASK        (P_MASK),
    .TIMEOUT           (TMO),
    .FAULT_ON_UNMAPPED (1'b1),
    .FAULT_RDATA       (FRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_fault   (m_fault),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .busy      (busy),
    .fault_cnt (fault_cnt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: the schedule of the transaction in flight.
  bit          check_en  = 1'b0;
  int          cur_c0    = -10;
  bit          cur_hit   = 1'b0;
  int          cur_sel   = 0;
  int          cur_L     = 0;
  int          cur_resp  = -10;
  logic [31:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic [31:0] exp_rdata = '0;
  logic        exp_fault = 1'b0;
  logic [15:0] exp_fcnt  = '0;

  // Lowest-index window that contains the address.
  function automatic void decode(input logic [31:0] a, output bit h, output int s);
    h = 1'b0;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (!h && ((a & MASKS[i]) == BASES[i])) begin
        h = 1'b1;
        s = i;
      end
    end
  endfunction

  bit           cmp_req, cmp_resp;
  logic [N-1:0] cmp_oh;

  // Per-cycle comparison of every output against the scheduled expectation.
  always @(negedge clk) begin
    if (check_en) begin
      cmp_req  = cur_hit && (cyc >= cur_c0 + 1) && (cyc <= cur_c0 + cur_L);
      cmp_resp = (cyc == cur_resp);
      cmp_oh   = '0;
      if (cmp_req) cmp_oh[cur_sel] = 1'b1;
      chk("m_ready",   m_ready,   cmp_resp);
      chk("m_rdata",   m_rdata,   cmp_resp ? exp_rdata : 32'h0);
      chk("m_fault",   m_fault,   cmp_resp ? exp_fault : 1'b0);
      chk("s_valid",   s_valid,   cmp_oh);
      chk("busy",      busy,      cmp_req || cmp_resp);
      chk("fault_cnt", fault_cnt, exp_fcnt);
      if (cmp_req) begin
        chk("s_addr",  s_addr,  cur_addr);
        chk("s_wdata", s_wdata, cur_wdata);
        chk("s_wstrb", s_wstrb, cur_wstrb);
      end
      if (cmp_resp && exp_fault && exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
    end
  end

  // One master transaction; the addressed slave raises ready in REQ cycle index w (0-based).
  // Latency is counted from the edge that launched m_valid to the edge that samples m_ready.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int w, input logic [31:0] rd_slave, input bit drop_early,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output int sv_cnt, output logic [N-1:0] sv_val);
    bit h;
    int s;
    decode(a, h, s);
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
    cur_c0 = cyc; cur_hit = h; cur_sel = s;
    cur_addr = a; cur_wdata = wd; cur_wstrb = ws;
    if (h) begin
      if (w >= TMO) begin
        cur_L = TMO; exp_rdata = FRD; exp_fault = 1'b1;
      end else begin
        cur_L = w + 1; exp_rdata = rd_slave; exp_fault = 1'b0;
      end
      cur_resp = cyc + 1 + cur_L;
    end else begin
      cur_L = 0; cur_resp = cyc + 1; exp_rdata = FRD; exp_fault = 1'b1;
    end
    lat = -1; rd = '0; flt = 1'b0; sv_cnt = 0; sv_val = '0;
    for (int k = 0; k < 60; k++) begin
      if (drop_early && cyc == cur_c0 + 1) m_valid = 1'b0;
      s_ready = N'($urandom);
      if (h) s_ready[s] = (cyc == cur_c0 + 1 + w);
      for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = (h && i == s) ? rd_slave : $urandom;
      @(negedge clk);
      if (s_valid != '0) begin sv_cnt++; sv_val = s_valid; end
      if (m_ready) begin lat = cyc - cur_c0 + 1; rd = m_rdata; flt = m_fault; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      n_cmp++; n_mis++;
      $display("FAIL txn_timeout: no m_ready within 60 cycles for addr %h", a);
    end
    @(posedge clk); #1;
    m_valid = 1'b0; s_ready = '0;
  endtask

  int          lat, svc;
  logic [31:0] rd;
  logic        flt;
  logic [N-1:0] svv;
  logic [31:0] ra;

  initial begin
    check_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_ready",   m_ready,   1'b0);
    chk("rst_m_rdata",   m_rdata,   32'h0);
    chk("rst_s_valid",   s_valid,   4'h0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_fault_cnt", fault_cnt, 16'h0);
    chk("rst_s_addr",    s_addr,    32'h0);
    rst = 1'b0;
    check_en = 1'b1;

    // Zero-wait read from slot 2.
    do_txn(32'h1000_0004, 32'h0, 4'h0, 0, 32'hA5A5_0001, 1'b0, lat, rd, flt, svc, svv);
    chk("t1_lat", lat, 3); chk("t1_rdata", rd, 32'hA5A5_0001); chk("t1_fault", flt, 1'b0);
    chk("t1_sv_cnt", svc, 1); chk("t1_sv_val", svv, 4'b0100);

    // Write to slot 0 with four wait cycles.
    do_txn(32'h0000_0010, 32'h0000_00C3, 4'hF, 4, 32'h1234_5678, 1'b0, lat, rd, flt, svc, svv);
    chk("t2_lat", lat, 7); chk("t2_fault", flt, 1'b0); chk("t2_sv_cnt", svc, 5);
    chk("t2_sv_val", svv, 4'b0001); chk("t2_s_wdata", s_wdata, 32'h0000_00C3); chk("t2_s_wstrb", s_wstrb, 4'hF);

    // Unmapped access.
    do_txn(32'h2000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, lat, rd, flt, svc, svv);
    chk("t3_lat", lat, 2); chk("t3_rdata", rd, FRD); chk("t3_fault", flt, 1'b1);
    chk("t3_sv_cnt", svc, 0); chk("t3_fcnt", fault_cnt, 16'd1);

    // Slave never ready: timeout after 8 REQ cycles.
    do_txn(32'h1000_0008, 32'h0, 4'h0, 1000, 32'h0BAD_0BAD, 1'b0, lat, rd, flt, svc, svv);
    chk("t4_lat", lat, 10); chk("t4_rdata", rd, FRD); chk("t4_fault", flt, 1'b1);
    chk("t4_sv_cnt", svc, 8); chk("t4_fcnt", fault_cnt, 16'd2);

    // Ready in the same cycle as the timeout: ready wins.
    do_txn(32'h1000_0008, 32'h0, 4'h0, 7, 32'h5A5A_7777, 1'b0, lat, rd, flt, svc, svv);
    chk("t5_lat", lat, 10); chk("t5_rdata", rd, 32'h5A5A_7777); chk("t5_fault", flt, 1'b0);
    chk("t5_sv_cnt", svc, 8);

    // Overlapping windows: slot 1 beats slot 3; outside the overlap slot 3 answers.
    do_txn(32'h4000_0010, 32'h0, 4'h0, 2, 32'h1111_0001, 1'b0, lat, rd, flt, svc, svv);
    chk("t6_sv_val", svv, 4'b0010); chk("t6_lat", lat, 5); chk("t6_rdata", rd, 32'h1111_0001);
    do_txn(32'h4000_0110, 32'h0, 4'h0, 0, 32'h3333_0003, 1'b0, lat, rd, flt, svc, svv);
    chk("t6b_sv_val", svv, 4'b1000); chk("t6b_rdata", rd, 32'h3333_0003);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0:       ra = {20'h0, 12'($urandom)};
        1:       ra = {24'h4000_00, 8'($urandom)};
        2:       ra = {28'h1000_000, 4'($urandom)};
        3:       ra = {16'h4000, 16'($urandom)};
        4:       ra = {16'h2000, 16'($urandom)};
        default: ra = $urandom;
      endcase
      do_txn(ra, $urandom, 4'($urandom), $urandom_range(0, 10), $urandom,
             ($urandom_range(0, 7) == 0), lat, rd, flt, svc, svv);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Asynchronous reset in the middle of REQ.
    @(posedge clk); #1;
    check_en = 1'b0;
    m_valid = 1'b1; m_addr = 32'h0000_0040; m_wdata = 32'h7777_7777; m_wstrb = 4'h3; s_ready = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_s_valid",   s_valid,   4'h0);
    chk("arst_busy",      busy,      1'b0);
    chk("arst_m_ready",   m_ready,   1'b0);
    chk("arst_s_addr",    s_addr,    32'h0);
    chk("arst_s_wdata",   s_wdata,   32'h0);
    chk("arst_s_wstrb",   s_wstrb,   4'h0);
    chk("arst_fault_cnt", fault_cnt, 16'h0);
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_hit = 1'b0; cur_resp = -10; cur_L = 0; exp_fcnt = '0;
    check_en = 1'b1;
    do_txn(32'h1000_0000, 32'h0, 4'h0, 0, 32'hC0DE_0002, 1'b0, lat, rd, flt, svc, svv);
    chk("t7_lat", lat, 3); chk("t7_rdata", rd, 32'hC0DE_0002); chk("t7_fault", flt, 1'b0);

    // Saturation: preload the counter near the top, then three faults.
    #1;
    force dut.fault_cnt = 16'hFFFE;
    exp_fcnt = 16'hFFFE;
    #1;
    release dut.fault_cnt;
    for (int t = 0; t < 3; t++) begin
      do_txn(32'h2000_0000 + 32'(t), 32'h0, 4'h0, 0, 32'h0, 1'b0, lat, rd, flt, svc, svv);
      chk("sat_fault", flt, 1'b1);
    end
    chk("sat_fcnt", fault_cnt, 16'hFFFF);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mmio_fabric.md
Name: mmio_fabric

Overview:
- Parametrised memory-mapped IO fabric between the CPU data port (valid/ready) and N peripheral slaves such as UART, SPI, divider registers and CLINT.
- Decodes each request by base/mask windows, forwards it to exactly one slave and returns a registered one-cycle response.
- Adds what the current hard-wired IO mux lacks: a per-transaction timeout, explicit unmapped-access fault reporting, and a saturating fault counter.
- Sits between the CPU core and all non-memory peripherals.

Parameters:
- NUM_SLAVES, 8, number of slave channels (1..16).
- SLAVE_BASE, NUM_SLAVES*32 bits, concatenated base addresses; slot i is bits [32*i+:32].
- SLAVE_MASK, NUM_SLAVES*32 bits, concatenated decode masks; slot i is bits [32*i+:32].
- TIMEOUT, 255, maximum cycles the fabric waits in REQ for slave ready; 0 disables the timeout.
- FAULT_ON_UNMAPPED, 1, when 1 an unmapped access sets m_fault; when 0 it completes silently.
- FAULT_RDATA, 32'h0000_0000, read data returned on a timeout or unmapped access.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- m_valid  in  1  master request; held high until m_ready.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_wstrb  in  4  byte strobes; 0 means read.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  32  response data; valid only while m_ready=1, 0 otherwise.
- m_fault  out  1  asserted together with m_ready on a timeout or unmapped fault.
- s_valid  out  NUM_SLAVES  one-hot slave request.
- s_addr  out  32  latched address, shared by all slaves.
- s_wdata  out  32  latched write data, shared.
- s_wstrb  out  4  latched strobes, shared.
- s_ready  in  NUM_SLAVES  per-slave ready.
- s_rdata  in  NUM_SLAVES*32  per-slave read data; slot i is bits [32*i+:32].
- busy  out  1  high in REQ and RESP.
- fault_cnt  out  16  saturating count of faults.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - All outputs go to 0, including s_addr, s_wdata, s_wstrb and fault_cnt.
  - An in-flight slave transaction is abandoned without a response.
- Decode (combinational):
  - hit[i] = ((m_addr & MASK[i]) == BASE[i]).
  - If several slots hit, the lowest index wins. This is deterministic; overlapping windows are legal.
- IDLE state, on m_valid=1:
  - Any hit: latch addr, wdata, wstrb and the selected index, then go to REQ. s_valid[sel] rises on the next cycle (registered).
  - No hit: go to RESP with rdata=FAULT_RDATA and fault=FAULT_ON_UNMAPPED.
- REQ state:
  - s_valid[sel]=1 and the timeout counter increments every cycle.
  - s_ready[sel]=1: capture s_rdata[sel], set fault=0, go to RESP. s_valid drops on the same edge.
  - Timeout (TIMEOUT!=0, counter==TIMEOUT-1, no ready): drop s_valid, go to RESP with rdata=FAULT_RDATA and fault=1.
  - ready and timeout in the same cycle: ready wins and no fault is raised.
  - s_ready on non-selected slaves is ignored.
- RESP state:
  - m_ready=1 for exactly one cycle, driving m_rdata and m_fault from the captured values.
  - If fault is set, fault_cnt increments, saturating at 16'hFFFF.
  - Next state is always IDLE; m_valid is not sampled in RESP.
- Latency:
  - A slave ready in the first cycle of s_valid gives m_ready 3 cycles after m_valid was sampled in IDLE.
  - Each additional slave wait cycle adds 1.
  - Unmapped accesses: m_ready 2 cycles after m_valid.
- Back-to-back requests: the master must deassert m_valid in the cycle after m_ready. A request still high in IDLE is treated as a new transaction.
- Master drops m_valid in REQ (contract violation):
  - The transaction completes normally and the response is still pulsed.
  - No abort is issued, so the slave handshake is never broken.
- Timeout counter: width is $clog2(TIMEOUT+1), minimum 1; it clears on entry to REQ.
- Outputs: m_rdata is forced to 0 whenever m_ready=0.

Decomposition:
- Package mmio_fabric_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2);
  - the counter-width function;
  - the FAULT_CNT_W=16 constant.
- Sub-module mmio_addr_decoder is the combinational priority decoder. Inputs: addr, BASE and MASK vectors. Outputs: hit, sel_idx.

Test Plan:
- Read, slave 2 (base 32'h1000_0000, mask 32'hFFFF_FFF0), s_ready in the first s_valid cycle with rdata 32'hA5A5_0001 -> m_ready 3 cycles after m_valid, m_rdata=32'hA5A5_0001, m_fault=0, s_valid=3'b100 for exactly 1 cycle.
- Write to slave 0 with m_wstrb=4'hF, wdata=32'h0000_00C3, ready after 4 wait cycles -> s_wdata=32'h0000_00C3 and s_wstrb=4'hF held stable throughout REQ; m_ready 7 cycles after m_valid.
- Unmapped address 32'h2000_0000, FAULT_ON_UNMAPPED=1 -> m_ready after 2 cycles, m_rdata=0, m_fault=1, fault_cnt=1, no s_valid bit ever asserts.
- TIMEOUT=8, slave never ready -> s_valid high for exactly 8 cycles, then m_ready with m_fault=1 and m_rdata=FAULT_RDATA. Separately, with s_ready arriving in cycle 8 (same cycle as the timeout) -> m_fault=0 and the slave data is returned.
- Overlapping windows on slots 1 and 3 -> slot 1 selected. In a separate test, rst pulsed mid-REQ -> all outputs 0 asynchronously and the next request completes normally.
- Force fault_cnt to 16'hFFFE, then issue 3 faults -> fault_cnt saturates at 16'hFFFF.
